// File: rtl/spike_event_encoder.sv
// spike_event_encoder: turns N parallel neuron spike lines into a serial stream
// of address events {neuron index, time-step stamp} delivered through a small
// FIFO to a valid/ready consumer. Spikes that collide with a still-pending
// spike of the same neuron set a sticky overflow flag.
//
// Optional feature macro: SPIKE_ENC_TIMESTAMP_EN
//   defined   -> time-step counter and per-entry stamp storage are built
//   undefined -> no stamp storage, timestep_tick ignored, event_ts tied to 0
module spike_event_encoder #(
  parameter int N      = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     timestep_tick,
  input  logic [N-1:0]             spikes_in,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [ADDR_W-1:0]        event_addr,
  output logic [TS_W-1:0]          event_ts,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N-1:0]        pending;
  logic [N-1:0]        clear_bit;
  logic [ADDR_W-1:0]   sel_idx;
  logic                push;
  logic                pop;
  logic                full;
  logic                dup_hit;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [ADDR_W-1:0]   mem_addr [DEPTH];

`ifdef SPIKE_ENC_TIMESTAMP_EN
  logic [TS_W-1:0]     mem_ts [DEPTH];
  logic [TS_W-1:0]     ts_cnt;
`else
  logic                unused_tick;
  assign unused_tick = timestep_tick;
`endif

  assign full        = (fifo_count == CNT_W'(DEPTH));
  assign event_valid = (fifo_count != '0);
  assign pop         = event_valid && event_ready;
  assign push        = enable && (pending != '0) && (!full || pop);

  // Priority selector: lowest-index pending neuron wins, and its bit is
  // cleared only when the push actually happens.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_idx   = '0;
    clear_bit = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = ADDR_W'(i);
    end
    if (push) clear_bit[sel_idx] = 1'b1;
  end

  // A new spike on a neuron whose previous spike has not yet been queued is lost.
  assign dup_hit = enable && ((spikes_in & pending & ~clear_bit) != '0);

  // Pending mask capture and sticky overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (enable) begin
      pending <= (pending & ~clear_bit) | spikes_in;
      if (dup_hit) overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; empty entries are masked at the output by event_valid.
    if (push) begin
      mem_addr[wr_ptr] <= sel_idx;
`ifdef SPIKE_ENC_TIMESTAMP_EN
      mem_ts[wr_ptr]   <= ts_cnt;
`endif
    end
  end

`ifdef SPIKE_ENC_TIMESTAMP_EN
  // Time-step counter; a push in the tick cycle stores the pre-increment value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
    end else if (enable && timestep_tick) begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  assign event_ts = event_valid ? mem_ts[rd_ptr] : '0;
`else
  assign event_ts = '0;
`endif

  assign event_addr = event_valid ? mem_addr[rd_ptr] : '0;

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
Output-side counterpart to the delayed-input neuron array: collects the spike_out lines of N neurons and turns them into a serial stream of address events. Each event carries the firing neuron's index and a time-step stamp. Events pass through a small FIFO to a valid/ready consumer such as a readout, an inter-core link or the next layer's spike router. Spikes that cannot be delivered are flagged, never silently lost.

Parameters:
N, 8, number of neuron spike inputs
ADDR_W, 3, event address width; must satisfy 2^ADDR_W >= N
DEPTH, 8, FIFO depth in entries; power of two, >= 2
TS_W, 8, time-step stamp width

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
enable  input  1  gates spike capture, FIFO push and time-step counting
timestep_tick  input  1  single-cycle pulse marking the end of a network time step
spikes_in  input  N  spike_out lines of N neurons, bit i = neuron i
event_valid  output  1  FIFO head holds an event
event_ready  input  1  consumer accepts the head event
event_addr  output  ADDR_W  neuron index of the head event
event_ts  output  TS_W  time-step stamp of the head event
fifo_count  output  clog2(DEPTH)+1  occupied entries
overflow  output  1  sticky flag: a spike was lost

Behaviour:
- Reset (synchronous, on the clk edge with reset=1): pending mask=0, FIFO empty, fifo_count=0, ts counter=0, overflow=0, event_valid=0, event_addr=0, event_ts=0.
- Capture, when enable=1, at each edge: pending <= (pending & ~clear_bit) | spikes_in.
- Selector:
  - Combinationally picks the lowest-index set bit of pending.
  - If a push is allowed that cycle, the FIFO is written with {addr, current ts} and that bit is cleared (clear_bit).
  - At most one push per cycle.
- Push allowed: enable=1 and pending!=0 and (fifo_count<DEPTH, or a pop occurs in the same cycle).
- Pop: event_valid & event_ready.
  - Pop advances the read pointer.
  - Simultaneous push and pop leaves fifo_count unchanged, including when the FIFO is full.
- Outputs:
  - event_valid = (fifo_count!=0).
  - event_addr and event_ts are the head entry, held stable while valid and not ready.
  - When empty, event_addr and event_ts are 0.
- Latency: a spike at the edge-t sample can be pushed at edge t+1. event_valid is then high in the cycle after edge t+1 (2-cycle minimum latency, uncontended).
- Pointers wrap modulo DEPTH.
- FIFO full and pop=0: pending bits hold; no push.
- Overflow sets when spikes_in[i]=1 while pending[i]=1 and bit i is not being cleared that cycle. The duplicate merges into the existing pending bit.
- Overflow clears only on reset.
- Time-step counter:
  - Increments by 1 on timestep_tick when enable=1, wrapping at 2^TS_W.
  - A push in the same cycle as a tick uses the pre-increment value.
- enable=0:
  - No capture, no push, counter holds.
  - Pop still operates, so the FIFO drains.
  - Pending contents are retained.
- Reset mid-transfer discards all pending and queued events; event_valid drops on the next cycle.
- Arithmetic is unsigned. Neuron index i is zero-extended to ADDR_W.

Optional Feature:
SPIKE_ENC_TIMESTAMP_EN
- Defined: time-step counter and TS_W bits per FIFO entry are present; event_ts behaves as above.
- Undefined: counter and ts storage are omitted; timestep_tick is ignored; event_ts is constant 0. Everything else is identical.

Test Plan:
- Single spike: reset, enable=1, spikes_in=8'h04 for one cycle, event_ready=1 -> event_valid high 2 cycles later for one cycle, event_addr=2, event_ts=0, overflow=0.
- Simultaneous spikes: spikes_in=8'h91 for one cycle, event_ready=1 -> events in order addr 0, 4, 7 on consecutive cycles; fifo_count never exceeds 2.
- Backpressure/full: event_ready=0, spikes_in=8'hFF then 8'h00 -> fifo_count=8 with pending=0 after 9 cycles. Spike 8'h01 then -> pending[0] held, no push. Then event_ready=1 -> 9 events in order addr 0..7 followed by addr 0, with a push and pop in the same cycle while full.
- Overflow: event_ready=0, FIFO full, spikes_in=8'h01 on two consecutive cycles -> overflow=1 and stays 1. Only one addr-0 event is queued after draining.
- Timestamps: with the macro defined, 3 timestep_tick pulses, then spike on bit 5 -> event_ts=3. Tick and push in the same cycle -> pre-increment ts. 256 ticks wrap to 0.
- Enable/reset: enable=0 with spikes_in=8'hFF -> no events; a prior queued event still drains. Reset asserted while fifo_count=3 -> next cycle event_valid=0, fifo_count=0, overflow=0.
